clock_gen_multi: RTL and testbench
==================================

CLOCK_GEN_MULTI -- requirements
Module: clock_gen_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent divided-clock channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 8, giving the divisor width per channel.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 4, giving the divisor loaded into every channel at reset (2..2^DIV_W-1).
REQ-004 clk100mhz  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 en  input  1  global count enable; low freezes all channels.
REQ-007 sync  input  1  one-cycle realign strobe for all channels.
REQ-008 load  input  NUM_CH  per-channel divisor load strobe.
REQ-009 div_in  input  NUM_CH*DIV_W  divisor values; channel i uses bits [i*DIV_W +: DIV_W].
REQ-010 clk_out  output  NUM_CH  registered divided clock per channel (fabric use / pin only, not a BUFG clock).
REQ-011 tick  output  NUM_CH  one-cycle strobe coincident with each rising edge of clk_out[i]; for use as a clock enable.
REQ-012 upd_pend  output  NUM_CH  high while a loaded divisor waits to be applied.

Function
REQ-013 Each channel SHALL hold an active divisor N, a pending divisor P, a pending flag, and a counter cnt of DIV_W bits.
REQ-014 Any divisor value 0 or 1, at load or reset, SHALL be clamped to 2.
REQ-015 On an edge with en=1 and sync=0: cnt_next = 0 if cnt == N-1, else cnt+1; cnt <= cnt_next.
REQ-016 On that edge clk_out[i] SHALL be registered as (cnt_next < N/2, integer floor) and tick[i] as (cnt_next == 0).
REQ-017 Resulting waveform: period N cycles, high floor(N/2) cycles, low ceil(N/2) cycles; N=4 gives 2 high/2 low; N=5 gives 2 high/3 low.
REQ-018 With en=0 and sync=0, cnt and clk_out SHALL hold, tick SHALL be 0, and load SHALL still be captured.
REQ-019 load[i]=1 SHALL capture the clamped div_in slice into P and set upd_pend[i] the next cycle; a later load before application overwrites P.
REQ-020 A pending P SHALL become N only at wrap (enabled edge with cnt == N-1), so the new period begins with that edge's tick; upd_pend clears on the same edge.
REQ-021 load on the same edge as wrap SHALL NOT apply that value at that wrap; it becomes pending for the next wrap.
REQ-022 sync=1 (regardless of en) SHALL set every channel's cnt to N'-1, clk_out to 0, and tick to 0, where N' = P if pending else N, and SHALL clear upd_pend.
REQ-023 load and sync on the same edge: the loaded value SHALL become N immediately (sync applies the newest divisor).
REQ-024 After sync, the first enabled edge SHALL produce tick=1 and clk_out=1 on all channels simultaneously (phase alignment).
REQ-025 Channels SHALL be fully independent except for shared en, sync, and rst.

Reset
REQ-026 rst=1 SHALL dominate all other inputs and set, per channel: N=P=DEFAULT_DIV (clamped), cnt=N-1, clk_out=0, tick=0, upd_pend=0.
REQ-027 On the first enabled edge after rst deasserts, every channel SHALL emit tick=1 and clk_out=1 (the same alignment as sync).
REQ-028 rst asserted mid-period or while an update is pending SHALL discard P and restore DEFAULT_DIV.

Verification
REQ-029 Reset release, en=1, defaults -> all clk_out toggle 1,1,0,0 repeating (25 MHz equivalent); tick high on cycles 1, 5, 9, ...
REQ-030 load[1] with div_in slice 5 mid-period -> upd_pend[1]=1 until ch1 wrap; the next period is 2 high/3 low; ch0, ch2, and ch3 are unchanged.
REQ-031 div_in slice 0 or 1 loaded -> the channel runs at N=2 (1 high/1 low, tick every 2 cycles).
REQ-032 en low for 3 cycles mid-period -> cnt and clk_out frozen, tick=0; the waveform resumes with no lost or extra edges.
REQ-033 Channels at N=3, 4, 6, 7, then sync -> all ticks coincide on the next enabled edge; load+sync on the same edge applies the new N immediately.
REQ-034 rst pulse during a pending update -> upd_pend=0, N=4, aligned restart as in REQ-027.

Source files
------------

// File: rtl/clock_gen_multi.sv
//------------------------------------------------------------------------------
// Module  : clock_gen_multi
// Purpose : NUM_CH independent integer clock dividers with phase-align strobe.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_gen_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                    clk100mhz,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       upd_pend
);

  localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_two     = DIV_W'(2);
  localparam logic [DIV_W-1:0] c_def_raw = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] c_def     = (c_def_raw < c_two) ? c_two : c_def_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] r_n;
    logic [DIV_W-1:0] r_p;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic [DIV_W-1:0] w_raw;
    logic [DIV_W-1:0] w_din;
    logic [DIV_W-1:0] w_nxt;
    logic [DIV_W-1:0] w_sync_n;
    logic             w_wrap;

    always_comb begin
      w_raw    = div_in[i*DIV_W +: DIV_W];
      w_din    = (w_raw < c_two) ? c_two : w_raw;
      w_wrap   = (r_cnt == (r_n - c_one));
      w_nxt    = w_wrap ? '0 : (r_cnt + c_one);
      // Sync realigns to the newest divisor: a same-edge load beats a pending one.
      w_sync_n = load[i] ? w_din : (r_pend ? r_p : r_n);
    end

    always_ff @(posedge clk100mhz) begin
      if (rst) begin
        r_n    <= c_def;
        r_p    <= c_def;
        r_pend <= 1'b0;
        r_cnt  <= c_def - c_one;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (sync) begin
        r_n    <= w_sync_n;
        r_p    <= w_sync_n;
        r_pend <= 1'b0;
        r_cnt  <= w_sync_n - c_one;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (en) begin
          r_cnt  <= w_nxt;
          r_clk  <= (w_nxt < (r_n >> 1));
          r_tick <= (w_nxt == '0);
          if (w_wrap && r_pend) begin
            r_n    <= r_p;
            r_pend <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
        end
        // A load on the wrap edge stays pending: it overrides the clear above.
        if (load[i]) begin
          r_p    <= w_din;
          r_pend <= 1'b1;
        end
      end
    end

    assign clk_out[i]  = r_clk;
    assign tick[i]     = r_tick;
    assign upd_pend[i] = r_pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_gen_multi.sv
//------------------------------------------------------------------------------
// Module  : tb_clock_gen_multi
// Purpose : Scoreboard bench for clock_gen_multi (4 channels, 8-bit divisors).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_gen_multi;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sync;
  logic [3:0]  load;
  logic [31:0] div_in;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  upd_pend;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] q[$];
  logic [11:0] got;
  logic [11:0] e;

  int m_n[4];
  int m_p[4];
  int m_cnt[4];
  bit m_pend[4];
  bit m_clk[4];
  bit m_tick[4];

  clock_gen_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
    .clk100mhz (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .load      (load),
    .div_in    (div_in),
    .clk_out   (clk_out),
    .tick      (tick),
    .upd_pend  (upd_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, advance the reference model, queue its outputs.
  task automatic drive(input logic r, input logic en_v, input logic s,
                       input logic [3:0] ld, input logic [31:0] dv);
    int d;
    int nn;
    bit applied;
    @(negedge clk);
    rst = r; en = en_v; sync = s; load = ld; div_in = dv;
    for (int c = 0; c < 4; c++) begin
      d = int'(dv[c*8 +: 8]);
      if (d < 2) d = 2;
      if (r) begin
        m_n[c] = 4; m_p[c] = 4; m_pend[c] = 0; m_cnt[c] = 3; m_clk[c] = 0; m_tick[c] = 0;
      end else if (s) begin
        nn = ld[c] ? d : (m_pend[c] ? m_p[c] : m_n[c]);
        m_n[c] = nn; m_p[c] = nn; m_cnt[c] = nn - 1;
        m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        applied = 0;
        if (en_v) begin
          if (m_cnt[c] == m_n[c] - 1) begin
            m_cnt[c] = 0;
            if (m_pend[c]) begin m_n[c] = m_p[c]; applied = 1; end
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
          m_clk[c]  = (m_cnt[c] < m_n[c] / 2);
          m_tick[c] = (m_cnt[c] == 0);
        end else begin
          m_tick[c] = 0;
        end
        if (applied) m_pend[c] = 0;
        if (ld[c]) begin m_p[c] = d; m_pend[c] = 1; end
      end
    end
    for (int c = 0; c < 4; c++) begin
      e[8+c] = m_clk[c];
      e[4+c] = m_tick[c];
      e[c]   = m_pend[c];
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset_sb: got %h expected %h", got, e); end
    end
    n_chk++;
    if ({clk_out, tick, upd_pend} !== 12'h000) begin
      n_fail++; $display("FAIL reset_zero: got %h expected 000", {clk_out, tick, upd_pend});
    end
  endtask

  task automatic test_default_wave();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL default_sb: got %h expected %h", got, e); end
      n_chk++;
      if (clk_out !== (((k % 4) < 2) ? 4'hF : 4'h0) || tick !== (((k % 4) == 0) ? 4'hF : 4'h0)) begin
        n_fail++; $display("FAIL default_pattern k=%0d: clk %h tick %h", k, clk_out, tick);
      end
    end
  endtask

  task automatic test_load_ch1();
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL load1_pre: got %h expected %h", got, e); end
    drive(1'b0, 1'b1, 1'b0, 4'b0010, 32'h0000_0500);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL load1_edge: got %h expected %h", got, e); end
    n_chk++;
    if (upd_pend !== 4'b0010) begin n_fail++; $display("FAIL load1_pend: got %b expected 0010", upd_pend); end
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL load1_run k=%0d: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_clamp();
    drive(1'b0, 1'b1, 1'b0, 4'b1100, 32'h0100_0000);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL clamp_load: got %h expected %h", got, e); end
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL clamp_run k=%0d: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_enable_freeze();
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, !(k >= 2 && k < 5), 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL freeze_sb k=%0d: got %h expected %h", k, got, e); end
      if (k >= 2 && k < 5) begin
        n_chk++;
        if (tick !== 4'h0) begin n_fail++; $display("FAIL freeze_tick k=%0d: got %h expected 0", k, tick); end
      end
    end
  endtask

  task automatic test_sync_align();
    drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h0706_0403);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL sync_load: got %h expected %h", got, e); end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL sync_pre k=%0d: got %h expected %h", k, got, e); end
    end
    drive(1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL sync_edge: got %h expected %h", got, e); end
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL sync_first: got %h expected %h", got, e); end
    n_chk++;
    if (clk_out !== 4'hF || tick !== 4'hF) begin
      n_fail++; $display("FAIL sync_align: clk %h tick %h expected F F", clk_out, tick);
    end
    // load and sync together: channel 0 must switch to 5 at once
    drive(1'b0, 1'b1, 1'b1, 4'b0001, 32'h0000_0005);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL ldsync_edge: got %h expected %h", got, e); end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL ldsync_run k=%0d: got %h expected %h", k, got, e); end
      if (k == 0 || k == 5) begin
        n_chk++;
        if (tick[0] !== 1'b1) begin n_fail++; $display("FAIL ldsync_tick k=%0d: got %b expected 1", k, tick[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_0006);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_load1: got %h expected %h", got, e); end
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_0003);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_load2: got %h expected %h", got, e); end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_run k=%0d: got %h expected %h", k, got, e); end
    end
    for (int k = 0; k < 16 && m_cnt[0] != m_n[0] - 1; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_seek k=%0d: got %h expected %h", k, got, e); end
    end
    // load on the wrap edge: must stay pending for the following wrap
    drive(1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_0008);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_wrapload: got %h expected %h", got, e); end
    n_chk++;
    if (upd_pend[0] !== 1'b1 || tick[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wrappend: pend %b tick %b expected 1 1", upd_pend[0], tick[0]);
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_after k=%0d: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_reset_pending();
    drive(1'b0, 1'b1, 1'b0, 4'b0010, 32'h0000_0900);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL rstp_load: got %h expected %h", got, e); end
    drive(1'b1, 1'b1, 1'b1, 4'b0001, 32'h0000_0007);
    got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
    if (got !== e) begin n_fail++; $display("FAIL rstp_rst: got %h expected %h", got, e); end
    n_chk++;
    if ({clk_out, tick, upd_pend} !== 12'h000) begin
      n_fail++; $display("FAIL rstp_zero: got %h expected 000", {clk_out, tick, upd_pend});
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
      got = {clk_out, tick, upd_pend}; e = q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL rstp_run k=%0d: got %h expected %h", k, got, e); end
      n_chk++;
      if (clk_out !== (((k % 4) < 2) ? 4'hF : 4'h0) || tick !== (((k % 4) == 0) ? 4'hF : 4'h0)) begin
        n_fail++; $display("FAIL rstp_pattern k=%0d: clk %h tick %h", k, clk_out, tick);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; load = 4'h0; div_in = 32'h0;
    test_reset();
    test_default_wave();
    test_load_ch1();
    test_clamp();
    test_enable_freeze();
    test_sync_align();
    test_back_to_back();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
